// File: rtl/midi_uart_pkg.sv
// Shared definitions for the MIDI UART: FSM state types and the default bit period.
package midi_uart_pkg;

  localparam int unsigned MIDI_CLK_DIV_DEFAULT = 687;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/midi_uart_if.sv
// Host-side handshake of the MIDI UART: transmit request/data and receive status/data.
interface midi_uart_if;
  logic        tx_start;
  logic [15:0] tx_data;
  logic        tx_int;
  logic        rx_int;
  logic [15:0] rx_data;
  logic        rx_err;

  modport master (
    output tx_start, tx_data,
    input  tx_int, rx_int, rx_data, rx_err
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_int, rx_int, rx_data, rx_err
  );
endinterface

// File: rtl/midi_uart_rx.sv
// MIDI receiver: 2-flop synchronizer, mid-bit sampling FSM, framing-error detection.
module midi_uart_rx
  import midi_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = MIDI_CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  output logic       rx_int,
  output logic [7:0] rx_byte,
  output logic       rx_err
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  rx_state_e      rx_state_q, rx_state_d;
  logic [CW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [3:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic [7:0]     rx_byte_q, rx_byte_d;
  logic           sync1_q, sync2_q, rs_prev_q;
  logic           rx_int1_q, rx_int1_d, rx_int2_q;
  logic           rx_err_q, rx_err_d;
  logic           rs, bit_end, half_end;

  assign rs       = sync2_q;
  assign bit_end  = (rx_cnt_q == CW'(CLK_DIV - 1));
  assign half_end = (rx_cnt_q == CW'(CLK_DIV / 2 - 1));

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_int1_d  = 1'b0;
    rx_err_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rs_prev_q && !rs) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
        end
      end
      RX_START: begin
        if (half_end) begin
          rx_cnt_d   = '0;
          rx_state_d = rs ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rs, rx_shift_q[7:1]};
          if (rx_bit_q == 4'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 4'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (bit_end) begin
          rx_cnt_d = '0;
          if (rs) begin
            rx_byte_d  = rx_shift_q;
            rx_int1_d  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_err_d   = 1'b1;
            rx_state_d = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rs) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rs_prev_q  <= 1'b1;
      rx_int1_q  <= 1'b0;
      rx_int2_q  <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      sync1_q    <= midi_rx;
      sync2_q    <= sync1_q;
      rs_prev_q  <= rs;
      rx_int1_q  <= rx_int1_d;
      rx_int2_q  <= rx_int1_q;
      rx_err_q   <= rx_err_d;
    end
  end

  // Two staggered pulse flops give the fixed two-cycle rx_int window.
  assign rx_int  = rx_int1_q | rx_int2_q;
  assign rx_byte = rx_byte_q;
  assign rx_err  = rx_err_q;

endmodule

// File: rtl/midi_uart.sv
// MIDI UART top: inline transmitter FSM plus the midi_uart_rx receiver.
module midi_uart
  import midi_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = MIDI_CLK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        midi_rx,
  output logic        midi_tx,
  midi_uart_if.slave  bus
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  tx_state_e      tx_state_q, tx_state_d;
  logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [3:0]     tx_bit_q, tx_bit_d;
  logic [7:0]     tx_shift_q, tx_shift_d;
  logic           midi_tx_q, midi_tx_d;
  logic           tx_int_q, tx_int_d;
  logic           tx_bit_end;
  logic [7:0]     rx_byte;
  logic           rx_int, rx_err;
  logic           unused_tx_hi;

  assign tx_bit_end   = (tx_cnt_q == CW'(CLK_DIV - 1));
  assign unused_tx_hi = ^bus.tx_data[15:8];

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    midi_tx_d  = midi_tx_q;
    tx_int_d   = tx_int_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.tx_start) begin
          tx_state_d = TX_START;
          tx_shift_d = bus.tx_data[7:0];
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          midi_tx_d  = 1'b0;
          tx_int_d   = 1'b1;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          midi_tx_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd7) begin
            tx_state_d = TX_STOP;
            midi_tx_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            midi_tx_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
          tx_int_d   = 1'b0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      midi_tx_q  <= 1'b1;
      tx_int_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      midi_tx_q  <= midi_tx_d;
      tx_int_q   <= tx_int_d;
    end
  end

  midi_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .midi_rx (midi_rx),
    .rx_int  (rx_int),
    .rx_byte (rx_byte),
    .rx_err  (rx_err)
  );

  assign midi_tx     = midi_tx_q;
  assign bus.tx_int  = tx_int_q;
  assign bus.rx_int  = rx_int;
  assign bus.rx_err  = rx_err;
  assign bus.rx_data = {8'h00, rx_byte};

endmodule

// File: tb/tb_midi_uart.sv
// Bench for midi_uart: cycle-exact TX line model, frame-level RX model, 687-divider loopback.
module tb_midi_uart;

  localparam int unsigned D  = 8;
  localparam int unsigned DR = 687;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic midi_rx = 1'b1;
  logic midi_tx;
  logic rt_line;

  int errors = 0;
  int checks = 0;

  midi_uart_if bus ();
  midi_uart_if rt_bus ();

  midi_uart #(.CLK_DIV(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .midi_rx (midi_rx),
    .midi_tx (midi_tx),
    .bus     (bus)
  );

  midi_uart #(.CLK_DIV(DR)) dut_rt (
    .clk     (clk),
    .reset   (reset),
    .midi_rx (rt_line),
    .midi_tx (rt_line),
    .bus     (rt_bus)
  );

  always #5 clk = ~clk;

  // Event monitor for the CLK_DIV=8 receiver.
  int   mon_int_cycles = 0;
  int   mon_int_rises  = 0;
  int   mon_err_pulses = 0;
  logic mon_int_prev   = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_int) mon_int_cycles <= mon_int_cycles + 1;
    if (bus.rx_int && !mon_int_prev) mon_int_rises <= mon_int_rises + 1;
    if (bus.rx_err) mon_err_pulses <= mon_err_pulses + 1;
    mon_int_prev <= bus.rx_int;
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (midi_tx !== 1'b1 || bus.tx_int !== 1'b0 || bus.rx_int !== 1'b0 ||
        bus.rx_err !== 1'b0 || bus.rx_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: tx=%b tx_int=%b rx_int=%b rx_err=%b rx_data=%h, want 1 0 0 0 0000",
               midi_tx, bus.tx_int, bus.rx_int, bus.rx_err, bus.rx_data);
    end
    checks++;
    if (rt_line !== 1'b1 || rt_bus.tx_int !== 1'b0 || rt_bus.rx_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rt_outputs: tx=%b tx_int=%b rx_data=%h, want 1 0 0000",
               rt_line, rt_bus.tx_int, rt_bus.rx_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Called at a negedge: request a frame there, then check the line every cycle
  // against the 10-bit frame; a junk request mid-frame must be ignored.
  task automatic run_tx_frame(input logic [15:0] d, input logic [15:0] junk);
    logic [9:0] bits;
    bits = {1'b1, d[7:0], 1'b0};
    bus.tx_start = 1'b1;
    bus.tx_data  = d;
    for (int k = 1; k <= int'(10 * D); k++) begin
      @(negedge clk);
      checks++;
      if (midi_tx !== bits[(k - 1) / int'(D)] || bus.tx_int !== 1'b1) begin
        errors++;
        $display("FAIL tx_bit: data=%h k=%0d got tx=%b tx_int=%b, want tx=%b tx_int=1",
                 d, k, midi_tx, bus.tx_int, bits[(k - 1) / int'(D)]);
      end
      bus.tx_start = (k == 40);
      bus.tx_data  = (k == 40) ? junk : d;
    end
    @(negedge clk);
    bus.tx_start = 1'b0;
    checks++;
    if (bus.tx_int !== 1'b0 || midi_tx !== 1'b1) begin
      errors++;
      $display("FAIL tx_done: data=%h got tx_int=%b tx=%b, want 0 1", d, bus.tx_int, midi_tx);
    end
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      midi_rx = f[i];
      repeat (D) @(negedge clk);
    end
    midi_rx = 1'b1;
  endtask

  task automatic test_tx_back_to_back();
    run_tx_frame(16'h0190, 16'h00AA);
    run_tx_frame(16'h01FE, 16'h0033);
  endtask

  task automatic test_rx_valid();
    int r0, c0, e0;
    r0 = mon_int_rises; c0 = mon_int_cycles; e0 = mon_err_pulses;
    drive_rx_frame(8'h3C, 1'b1);
    repeat (3 * D) @(negedge clk);
    checks++;
    if (mon_int_rises - r0 != 1 || mon_int_cycles - c0 != 2) begin
      errors++;
      $display("FAIL rx_valid_int: rises=%0d cycles=%0d, want 1 2", mon_int_rises - r0, mon_int_cycles - c0);
    end
    checks++;
    if (mon_err_pulses != e0) begin
      errors++;
      $display("FAIL rx_valid_err: pulses=%0d, want 0", mon_err_pulses - e0);
    end
    checks++;
    if (bus.rx_data !== 16'h003C) begin
      errors++;
      $display("FAIL rx_valid_data: got %h want 003c", bus.rx_data);
    end
  endtask

  task automatic test_rx_framing();
    int r0, e0;
    r0 = mon_int_rises; e0 = mon_err_pulses;
    drive_rx_frame(8'hA5, 1'b0);
    midi_rx = 1'b0;
    repeat (40) @(negedge clk);
    midi_rx = 1'b1;
    repeat (2 * D) @(negedge clk);
    checks++;
    if (mon_err_pulses - e0 != 1 || mon_int_rises != r0) begin
      errors++;
      $display("FAIL rx_break: err=%0d int=%0d, want 1 0", mon_err_pulses - e0, mon_int_rises - r0);
    end
    checks++;
    if (bus.rx_data !== 16'h003C) begin
      errors++;
      $display("FAIL rx_break_data: got %h want 003c", bus.rx_data);
    end
    r0 = mon_int_rises; e0 = mon_err_pulses;
    drive_rx_frame(8'h12, 1'b1);
    repeat (3 * D) @(negedge clk);
    checks++;
    if (bus.rx_data !== 16'h0012 || mon_int_rises - r0 != 1 || mon_err_pulses != e0) begin
      errors++;
      $display("FAIL rx_after_break: data=%h int=%0d err=%0d, want 0012 1 0",
               bus.rx_data, mon_int_rises - r0, mon_err_pulses - e0);
    end
  endtask

  task automatic test_rx_glitch();
    int r0, e0;
    r0 = mon_int_rises; e0 = mon_err_pulses;
    midi_rx = 1'b0;
    repeat (2) @(negedge clk);
    midi_rx = 1'b1;
    repeat (3 * D) @(negedge clk);
    checks++;
    if (mon_int_rises != r0 || mon_err_pulses != e0 || bus.rx_data !== 16'h0012) begin
      errors++;
      $display("FAIL rx_glitch: int=%0d err=%0d data=%h, want 0 0 0012",
               mon_int_rises - r0, mon_err_pulses - e0, bus.rx_data);
    end
  endtask

  task automatic test_reset_abort();
    logic [9:0] f;
    int r0;
    f = {1'b1, 8'h0F, 1'b0};
    bus.tx_start = 1'b1;
    bus.tx_data  = 16'h0055;
    for (int k = 0; k < 30; k++) begin
      midi_rx = f[k / int'(D)];
      @(negedge clk);
      bus.tx_start = 1'b0;
    end
    reset   = 1'b1;
    midi_rx = 1'b1;
    r0 = mon_int_rises;
    @(negedge clk);
    checks++;
    if (midi_tx !== 1'b1 || bus.tx_int !== 1'b0 || bus.rx_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_abort: tx=%b tx_int=%b rx_data=%h, want 1 0 0000", midi_tx, bus.tx_int, bus.rx_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12 * D) @(negedge clk);
    checks++;
    if (mon_int_rises != r0 || midi_tx !== 1'b1 || bus.tx_int !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_after: int=%0d tx=%b tx_int=%b, want 0 1 0",
               mon_int_rises - r0, midi_tx, bus.tx_int);
    end
  endtask

  task automatic test_random_concurrent();
    for (int it = 0; it < 6; it++) begin
      logic [15:0] d, junk;
      logic [7:0]  b;
      int r0;
      d    = 16'($urandom);
      junk = 16'($urandom);
      b    = 8'($urandom);
      r0   = mon_int_rises;
      fork
        run_tx_frame(d, junk);
        drive_rx_frame(b, 1'b1);
      join
      repeat (2 * D) @(negedge clk);
      checks++;
      if (bus.rx_data !== {8'h00, b} || mon_int_rises - r0 != 1) begin
        errors++;
        $display("FAIL rand_rx: got %h int=%0d, want %h 1", bus.rx_data, mon_int_rises - r0, {8'h00, b});
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
  endtask

  task automatic test_roundtrip_687();
    logic seen;
    int   lat, errs;
    seen = 1'b0; lat = 0; errs = 0;
    rt_bus.tx_data  = 16'h0090;
    rt_bus.tx_start = 1'b1;
    for (int n = 1; n <= int'(10 * DR) + 40; n++) begin
      @(negedge clk);
      rt_bus.tx_start = 1'b0;
      if (rt_bus.rx_err) errs++;
      if (rt_bus.rx_int) seen = 1'b1;
      else if (seen) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat == 0 || lat > int'(10 * DR) + 6) begin
      errors++;
      $display("FAIL rt_latency: got %0d cycles (0 = timeout), want 1..%0d", lat, 10 * DR + 6);
    end
    checks++;
    if (rt_bus.rx_data !== 16'h0090 || errs != 0) begin
      errors++;
      $display("FAIL rt_data: got %h err=%0d, want 0090 0", rt_bus.rx_data, errs);
    end
  endtask

  initial begin
    bus.tx_start    = 1'b0;
    bus.tx_data     = '0;
    rt_bus.tx_start = 1'b0;
    rt_bus.tx_data  = '0;
    @(negedge clk);
    test_reset();
    test_tx_back_to_back();
    test_rx_valid();
    test_rx_framing();
    test_rx_glitch();
    test_reset_abort();
    test_random_concurrent();
    test_roundtrip_687();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
